rf_write_arbiter: RTL and testbench

- Shares the single register-file write port between the Write Back stage (primary, no backpressure) and an external write requester such as an I/O or loader unit (valid/ready handshake).
- Sits between Write Back and the register file.
- Holds WB writes in a 2-entry buffer when the external requester is force-granted, and raises stall_req toward the pipeline so the buffer cannot overflow.
- Guarantees the external requester a grant within STARVE_LIMIT cycles.

---
 rtl/rf_write_arbiter_pkg.sv | 19 +
 rtl/rf_write_arbiter_skid_fifo.sv | 54 +++++
 rtl/rf_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_rf_write_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: write record, arbiter
// state encoding and default widths.
package rf_write_arbiter_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 3;

    typedef struct packed {
        logic [AW_DEF-1:0] dst;
        logic [DW_DEF-1:0] data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        NORMAL,
        FORCE_EXT,
        DRAIN
    } arb_state_e;

endpackage

// File: rtl/rf_write_arbiter_skid_fifo.sv
// Two-entry FIFO holding Write Back writes displaced by a forced external grant.
// An enqueue into a full FIFO is accepted only when a dequeue frees a slot.
module rf_write_arbiter_skid_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter type T = rf_wr_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enq_i,
    input  T           din_i,
    input  logic       deq_i,
    output T           head_o,
    output logic [1:0] count_o,
    output logic       full_o
);

    T           mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       wr_ptr;
    logic       enq_ok;
    logic       deq_ok;

    assign full_o  = (count_q == 2'd2);
    assign enq_ok  = enq_i && (!full_o || deq_i);
    assign deq_ok  = deq_i && (count_q != 2'd0);
    // With two slots the free slot is the head itself when empty or full.
    assign wr_ptr  = rd_ptr_q ^ count_q[0];
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ deq_ok;
        count_d  = count_q + {1'b0, enq_ok} - {1'b0, deq_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            mem_q[wr_ptr] <= din_i;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between Write Back (never
// refused) and an external valid/ready requester with a bounded grant wait.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_wr_en,
    input  logic [AW-1:0] wb_dst,
    input  logic [DW-1:0] wb_data,
    input  logic          ext_valid,
    input  logic [AW-1:0] ext_dst,
    input  logic [DW-1:0] ext_data,
    output logic          ext_ready,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_dst,
    output logic [DW-1:0] rf_data,
    output logic          stall_req,
    output logic          err_overflow
);

    localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } wr_t;

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rf_wr_en_q, rf_wr_en_d;
    wr_t           rf_q, rf_d;
    logic          ovf_q, ovf_d;

    wr_t           wb_req, ext_req;
    wr_t           fifo_head;
    logic [1:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_enq;
    logic          sel_buf, sel_wb, sel_ext;
    logic          enq_drop;
    logic [1:0]    count_next;
    logic          hit;

    assign wb_req  = '{dst: wb_dst, data: wb_data};
    assign ext_req = '{dst: ext_dst, data: ext_data};
    // Saturating counter: reaching LIMIT-1 means the next ungranted cycle forces.
    assign hit     = (starve_q == LIMIT_M1);

    rf_write_arbiter_skid_fifo #(
        .T (wr_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .enq_i   (fifo_enq),
        .din_i   (wb_req),
        .deq_i   (sel_buf),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    always_comb begin
        sel_buf    = 1'b0;
        sel_wb     = 1'b0;
        sel_ext    = 1'b0;
        fifo_enq   = 1'b0;
        starve_d   = starve_q;
        state_d    = state_q;
        rf_wr_en_d = 1'b0;
        rf_d       = rf_q;
        ovf_d      = ovf_q;

        if (state_q == FORCE_EXT && ext_valid) begin
            sel_ext  = 1'b1;
            fifo_enq = wb_wr_en;
        end else if (fifo_count != 2'd0) begin
            sel_buf  = 1'b1;
            fifo_enq = wb_wr_en;
        end else if (wb_wr_en) begin
            sel_wb = 1'b1;
        end else if (ext_valid) begin
            sel_ext = 1'b1;
        end

        enq_drop   = fifo_enq && fifo_full && !sel_buf;
        count_next = fifo_count - {1'b0, sel_buf} + {1'b0, fifo_enq && !enq_drop};

        if (state_q == FORCE_EXT || sel_ext) begin
            starve_d = '0;
        end else if (ext_valid && !hit) begin
            starve_d = starve_q + 1'b1;
        end

        if (state_q != FORCE_EXT && ext_valid && !sel_ext && hit && count_next == 2'd0) begin
            state_d = FORCE_EXT;
        end else if (count_next != 2'd0) begin
            state_d = DRAIN;
        end else begin
            state_d = NORMAL;
        end

        rf_wr_en_d = sel_buf || sel_wb || sel_ext;
        if (sel_buf) begin
            rf_d = fifo_head;
        end else if (sel_wb) begin
            rf_d = wb_req;
        end else if (sel_ext) begin
            rf_d = ext_req;
        end

        if (enq_drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NORMAL;
            starve_q   <= '0;
            rf_wr_en_q <= 1'b0;
            rf_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_q       <= rf_d;
            ovf_q      <= ovf_d;
        end
    end

    // Combinational outputs are masked during reset so the idle state grants nothing.
    assign ext_ready    = rst_n && sel_ext;
    assign stall_req    = rst_n && ((fifo_count != 2'd0) || (state_q == FORCE_EXT) ||
                                    (state_q != FORCE_EXT && ext_valid && hit));
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_dst       = rf_q.dst;
    assign rf_data      = rf_q.data;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts
// each cycle's grant and register-file write; a monitor checks rf_* as it appears.
module tb_rf_write_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_wr_en = 1'b0;
    logic [AW-1:0] wb_dst = '0;
    logic [DW-1:0] wb_data = '0;
    logic          ext_valid = 1'b0;
    logic [AW-1:0] ext_dst = '0;
    logic [DW-1:0] ext_data = '0;
    logic          ext_ready;
    logic          rf_wr_en;
    logic [AW-1:0] rf_dst;
    logic [DW-1:0] rf_data;
    logic          stall_req;
    logic          err_overflow;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .DW           (DW),
        .AW           (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_wr_en     (wb_wr_en),
        .wb_dst       (wb_dst),
        .wb_data      (wb_data),
        .ext_valid    (ext_valid),
        .ext_dst      (ext_dst),
        .ext_data     (ext_data),
        .ext_ready    (ext_ready),
        .rf_wr_en     (rf_wr_en),
        .rf_dst       (rf_dst),
        .rf_data      (rf_data),
        .stall_req    (stall_req),
        .err_overflow (err_overflow)
    );

    typedef struct { bit en; int dst; int data; } rfexp_t;
    typedef struct { int dst; int data; } mwr_t;

    rfexp_t exp_q[$];
    mwr_t   mbuf[$];
    bit     m_force = 1'b0;
    bit     m_ovf = 1'b0;
    int     m_starve = 0;
    int     m_dst = 0;
    int     m_data = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive inputs, predict the arbiter's decision, check the
    // combinational outputs and queue the register-file write due next cycle.
    task automatic step(input bit w, input logic [AW-1:0] wd, input logic [DW-1:0] wv,
                        input bit e, input logic [AW-1:0] ed, input logic [DW-1:0] evd,
                        output bit got_ready, output bit got_stall);
        bit     x_ready;
        bit     x_stall;
        rfexp_t x;
        mwr_t   b;
        @(negedge clk);
        wb_wr_en  = w;
        wb_dst    = wd;
        wb_data   = wv;
        ext_valid = e;
        ext_dst   = ed;
        ext_data  = evd;
        #1;
        chk("err_overflow", int'(err_overflow), int'(m_ovf));
        x_stall = (mbuf.size() != 0) || m_force || (e && (m_starve + 1 == LIMIT));
        x_ready = 1'b0;
        x.en    = 1'b1;
        x.dst   = m_dst;
        x.data  = m_data;
        if (m_force && e) begin
            x_ready = 1'b1;
            x.dst   = int'(ed);
            x.data  = int'(evd);
            if (w) begin
                if (mbuf.size() < 2) mbuf.push_back('{int'(wd), int'(wv)});
                else m_ovf = 1'b1;
            end
            m_starve = 0;
            m_force  = 1'b0;
        end else begin
            if (mbuf.size() != 0) begin
                b      = mbuf.pop_front();
                x.dst  = b.dst;
                x.data = b.data;
                if (w) mbuf.push_back('{int'(wd), int'(wv)});
            end else if (w) begin
                x.dst  = int'(wd);
                x.data = int'(wv);
            end else if (e) begin
                x_ready = 1'b1;
                x.dst   = int'(ed);
                x.data  = int'(evd);
            end else begin
                x.en = 1'b0;
            end
            if (m_force) begin
                m_force  = 1'b0;
                m_starve = 0;
            end else if (x_ready) begin
                m_starve = 0;
            end else if (e) begin
                if (m_starve + 1 == LIMIT) m_force = (mbuf.size() == 0);
                else m_starve++;
            end
        end
        chk("ext_ready", int'(ext_ready), int'(x_ready));
        chk("stall_req", int'(stall_req), int'(x_stall));
        got_ready = ext_ready;
        got_stall = stall_req;
        if (x.en) begin
            m_dst  = x.dst;
            m_data = x.data;
        end
        exp_q.push_back(x);
    endtask

    task automatic do_reset(input bit hold_ext);
        @(negedge clk);
        rst_n     = 1'b0;
        wb_wr_en  = 1'b0;
        ext_valid = hold_ext;
        ext_dst   = 3'd5;
        ext_data  = 8'hC3;
        #1;
        chk("rst_rf_wr_en", int'(rf_wr_en), 0);
        chk("rst_rf_dst", int'(rf_dst), 0);
        chk("rst_rf_data", int'(rf_data), 0);
        chk("rst_stall_req", int'(stall_req), 0);
        chk("rst_ext_ready", int'(ext_ready), 0);
        chk("rst_err_overflow", int'(err_overflow), 0);
        mbuf.delete();
        m_force  = 1'b0;
        m_ovf    = 1'b0;
        m_starve = 0;
        m_dst    = 0;
        m_data   = 0;
        repeat (2) @(negedge clk);
        ext_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents a register-file port state to compare.
    initial begin
        rfexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rf_wr_en", int'(rf_wr_en), int'(e.en));
                chk("rf_dst", int'(rf_dst), e.dst);
                chk("rf_data", int'(rf_data), e.data);
            end
        end
    end

    initial begin
        bit            r, s;
        bit            w;
        bit            ev_hold;
        bit            sh1, sh2;
        logic [AW-1:0] ed;
        logic [DW-1:0] edat;

        do_reset(1'b1);

        // WB-only write, then an idle external grant.
        step(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, r, s);
        chk("wb_only_stall", int'(s), 0);
        step(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h11, r, s);
        chk("idle_ext_ready", int'(r), 1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);

        // Starvation: WB every cycle; pipeline honours stall with one write in flight.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 3'(i), 8'(8'h30 + i), 1'b1, 3'd2, 8'hE1, r, s);
            chk("starve_ready", int'(r), (i == 5) ? 1 : 0);
            chk("starve_stall", int'(s), (i >= 4) ? 1 : 0);
        end
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        chk("drain_stall", int'(s), 1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        chk("drained_stall", int'(s), 0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);

        // Stall ignored: WB keeps writing through and after the forced grant.
        ev_hold = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 3'(i), 8'(8'h70 + i), ev_hold, 3'd7, 8'h9C, r, s);
            if (r) ev_hold = 1'b0;
        end
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);

        // Reset while a displaced WB write is still buffered.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'(i), 8'(8'hA0 + i), 1'b1, 3'd4, 8'h44, r, s);
        end
        chk("pre_reset_buffered", int'(s), 1);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        end

        // Randomized traffic; first part honours stall_req, later part ignores it.
        ev_hold = 1'b0;
        sh1     = 1'b0;
        sh2     = 1'b0;
        ed      = '0;
        edat    = '0;
        for (int unsigned c = 0; c < 3000; c++) begin
            w = ($urandom_range(0, 99) < 65);
            if (c < 2000 && sh2) w = 1'b0;
            if (!ev_hold && $urandom_range(0, 99) < 30) begin
                ev_hold = 1'b1;
                ed      = AW'($urandom);
                edat    = DW'($urandom);
            end else if (ev_hold && $urandom_range(0, 99) < 3) begin
                ev_hold = 1'b0;
            end
            step(w, AW'($urandom), DW'($urandom), ev_hold, ed, edat, r, s);
            if (r) ev_hold = 1'b0;
            sh2 = sh1;
            sh1 = s;
        end

        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, r, s);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
